// File: rtl/lcd_receiver_if.sv
// 8-bit HD44780-style LCD bus as seen between the display driver (master) and the responder (slave).
interface lcd_receiver_if;
  logic       EN;
  logic       RW;
  logic       RS;
  logic [7:0] data;

  modport master (output EN, RW, RS, data);
  modport slave  (input  EN, RW, RS, data);
endinterface

// File: rtl/lcd_receiver.sv
// HD44780-compatible bus responder: decodes EN falling-edge strobes into a 2x16 character image,
// address counter and mode flags, with busy timing, overrun and read-strobe error flags.
module lcd_receiver #(
  parameter int EXEC_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic              clk,
  input  logic              rst_n,
  lcd_receiver_if.slave     bus,
  input  logic [4:0]        rd_addr,
  output logic [7:0]        rd_char,
  output logic [6:0]        ac,
  output logic              busy,
  output logic              disp_on,
  output logic              cursor_on,
  output logic              blink_on,
  output logic              two_line,
  output logic              inc_mode,
  output logic              cmd_valid,
  output logic              overrun,
  output logic              rw_err
);

  localparam int MAXC = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic            en_q, rs_q, rw_q;
  logic [7:0]      data_q;
  logic [6:0]      ac_q, ac_d;
  logic            disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic            two_q, two_d, inc_q, inc_d;
  logic            cmd_valid_q, cmd_valid_d, overrun_q, overrun_d, rw_err_q, rw_err_d;
  logic [7:0]      rd_char_q;
  logic [7:0]      cell_q [32];
  logic            cell_we;
  logic [4:0]      cell_wa;
  logic [7:0]      cell_wd;
  logic            strobe;

  // DDRAM address wraps between the two 40-cell lines: 0x27<->0x40, 0x67<->0x00.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  assign strobe = en_q & ~bus.EN;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    ac_d        = ac_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    two_d       = two_q;
    inc_d       = inc_q;
    cmd_valid_d = 1'b0;
    overrun_d   = overrun_q;
    rw_err_d    = rw_err_q;
    cell_we     = 1'b0;
    cell_wa     = idx_q;
    cell_wd     = 8'h20;

    if (state_q == IDLE) begin
      if (strobe && rw_q) begin
        rw_err_d = 1'b1;
      end else if (strobe) begin
        cmd_valid_d = 1'b1;
        state_d     = BUSY;
        cnt_d       = CW'(EXEC_CYCLES - 1);
        if (rs_q) begin
          if (ac_q[5:4] == 2'b00) begin
            cell_we = 1'b1;
            cell_wa = {ac_q[6], ac_q[3:0]};
            cell_wd = data_q;
          end
          ac_d = ac_step(ac_q, inc_q);
        end else begin
          casez (data_q)
            8'b1???????: begin
              if (data_q[6:0] <= 7'h27 || (data_q[6:0] >= 7'h40 && data_q[6:0] <= 7'h67))
                ac_d = data_q[6:0];
            end
            8'b01??????: ;
            8'b001?????: two_d = data_q[3];
            8'b0001????: begin
              if (!data_q[3]) ac_d = ac_step(ac_q, data_q[2]);
            end
            8'b00001???: begin
              disp_d  = data_q[2];
              cur_d   = data_q[1];
              blink_d = data_q[0];
            end
            8'b000001??: inc_d = data_q[1];
            8'b0000001?: begin
              ac_d  = 7'h00;
              cnt_d = CW'(CLEAR_CYCLES - 1);
            end
            8'b00000001: begin
              ac_d    = 7'h00;
              inc_d   = 1'b1;
              state_d = CLEAR;
              cnt_d   = CW'(CLEAR_CYCLES - 1);
              idx_d   = 5'd0;
            end
            default: ;
          endcase
        end
      end
    end else begin
      if (strobe) begin
        overrun_d = 1'b1;
        if (rw_q) rw_err_d = 1'b1;
      end
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      if (state_q == CLEAR) begin
        // One cell per cycle; the shared busy count keeps running underneath.
        cell_we = 1'b1;
        idx_d   = idx_q + 5'd1;
        if (idx_q == 5'd31) state_d = (cnt_q == '0) ? IDLE : BUSY;
      end else if (cnt_q == '0) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= 8'h00;
      ac_q        <= 7'h00;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      two_q       <= 1'b0;
      inc_q       <= 1'b1;
      cmd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      rw_err_q    <= 1'b0;
      rd_char_q   <= 8'h20;
      for (int i = 0; i < 32; i++) cell_q[i] <= 8'h20;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      en_q        <= bus.EN;
      if (bus.EN) begin
        rs_q   <= bus.RS;
        rw_q   <= bus.RW;
        data_q <= bus.data;
      end
      ac_q        <= ac_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      two_q       <= two_d;
      inc_q       <= inc_d;
      cmd_valid_q <= cmd_valid_d;
      overrun_q   <= overrun_d;
      rw_err_q    <= rw_err_d;
      rd_char_q   <= cell_q[rd_addr];
      if (cell_we) cell_q[cell_wa] <= cell_wd;
    end
  end

  assign rd_char   = rd_char_q;
  assign ac        = ac_q;
  assign busy      = (state_q != IDLE);
  assign disp_on   = disp_q;
  assign cursor_on = cur_q;
  assign blink_on  = blink_q;
  assign two_line  = two_q;
  assign inc_mode  = inc_q;
  assign cmd_valid = cmd_valid_q;
  assign overrun   = overrun_q;
  assign rw_err    = rw_err_q;

endmodule

// File: tb/tb_lcd_receiver.sv
// Directed bench for lcd_receiver: table of command/data strobes plus hand-timed clear, reset and busy-edge sequences.
module tb_lcd_receiver;

  localparam int E = 4;
  localparam int C = 40;

  logic       clk;
  logic       rst_n;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [6:0] ac;
  logic       busy, disp_on, cursor_on, blink_on, two_line, inc_mode;
  logic       cmd_valid, overrun, rw_err;
  logic [4:0] flags;

  lcd_receiver_if bus ();

  lcd_receiver #(.EXEC_CYCLES(E), .CLEAR_CYCLES(C)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_addr(rd_addr), .rd_char(rd_char),
    .ac(ac), .busy(busy), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .inc_mode(inc_mode), .cmd_valid(cmd_valid),
    .overrun(overrun), .rw_err(rw_err)
  );

  assign flags = {disp_on, cursor_on, blink_on, two_line, inc_mode};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         blen;
    logic [6:0] ac;
    logic [4:0] flags;
    logic       chk_rd;
    logic [4:0] ra;
    logic [7:0] ch;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t row(input logic rs, input logic [7:0] d, input int blen, input logic [6:0] a,
                               input logic [4:0] f, input logic c, input logic [4:0] ra, input logic [7:0] ch);
    vec_t v;
    v.rs = rs; v.d = d; v.blen = blen; v.ac = a; v.flags = f; v.chk_rd = c; v.ra = ra; v.ch = ch;
    return v;
  endfunction

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.EN = 1'b1; bus.RS = rs; bus.RW = rw; bus.data = d;
    @(negedge clk);
    bus.EN = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin n++; @(negedge clk); end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic apply(input vec_t v, input int i);
    int n = 0;
    strobe(v.rs, 1'b0, v.d);
    @(negedge clk);
    chk($sformatf("row%0d_cmd_valid", i), {31'd0, cmd_valid}, 32'd1);
    while (busy && n < 1000) begin n++; @(negedge clk); end
    chk($sformatf("row%0d_busy_len", i), n, v.blen);
    chk($sformatf("row%0d_ac", i), {25'd0, ac}, {25'd0, v.ac});
    chk($sformatf("row%0d_flags", i), {27'd0, flags}, {27'd0, v.flags});
    if (v.chk_rd) begin
      rd_addr = v.ra;
      @(negedge clk);
      chk($sformatf("row%0d_cell%0d", i, v.ra), {24'd0, rd_char}, {24'd0, v.ch});
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      @(negedge clk);
      chk($sformatf("%s_cell%0d", tag, i), {24'd0, rd_char}, 32'h20);
    end
  endtask

  initial begin
    int bc;
    rst_n = 1'b0; bus.EN = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0; bus.data = 8'h00; rd_addr = 5'd0;

    // flags = {disp, cursor, blink, two_line, inc}
    tbl.push_back(row(0, 8'h38, E, 7'h00, 5'b00011, 0, 0, 0));
    tbl.push_back(row(0, 8'h0E, E, 7'h00, 5'b11011, 0, 0, 0));
    tbl.push_back(row(0, 8'h06, E, 7'h00, 5'b11011, 0, 0, 0));
    tbl.push_back(row(0, 8'h80, E, 7'h00, 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h4C, E, 7'h01, 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h4F, E, 7'h02, 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h41, E, 7'h03, 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h44, E, 7'h04, 5'b11011, 1, 3, 8'h44));
    for (int i = 0; i < 6; i++) tbl.push_back(row(0, 8'h14, E, 7'(5 + i), 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h5B, E, 7'h0B, 5'b11011, 1, 10, 8'h5B));
    tbl.push_back(row(0, 8'hA7, E, 7'h27, 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h41, E, 7'h40, 5'b11011, 1, 7, 8'h20));
    tbl.push_back(row(0, 8'hC0, E, 7'h40, 5'b11011, 0, 0, 0));
    tbl.push_back(row(1, 8'h2B, E, 7'h41, 5'b11011, 1, 16, 8'h2B));
    tbl.push_back(row(0, 8'h04, E, 7'h41, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'hC0, E, 7'h40, 5'b11010, 0, 0, 0));
    tbl.push_back(row(1, 8'h30, E, 7'h27, 5'b11010, 1, 16, 8'h30));
    tbl.push_back(row(0, 8'h10, E, 7'h26, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h18, E, 7'h26, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h40, E, 7'h26, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h00, E, 7'h26, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'hE8, E, 7'h26, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h02, C, 7'h00, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h10, E, 7'h67, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h14, E, 7'h00, 5'b11010, 0, 0, 0));
    tbl.push_back(row(0, 8'h20, E, 7'h00, 5'b11000, 0, 0, 0));
    tbl.push_back(row(0, 8'h0D, E, 7'h00, 5'b10100, 0, 0, 0));
    tbl.push_back(row(0, 8'h06, E, 7'h00, 5'b10101, 1, 0, 8'h4C));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd_char", {24'd0, rd_char}, 32'h20);
    chk("rst_ac", {25'd0, ac}, 32'h0);
    chk("rst_flags", {27'd0, flags}, 32'h01);
    chk("rst_busy_valid_err", {29'd0, busy, cmd_valid, overrun | rw_err}, 32'h0);
    read_all("rst");

    foreach (tbl[i]) apply(tbl[i], i);

    // Clear with populated cells; a data strobe lands mid-clear.
    strobe(1'b0, 1'b0, 8'h01);
    bc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (k == 1) begin
        chk("clr_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        chk("clr_ac", {25'd0, ac}, 32'h0);
        rd_addr = 5'd3;
      end
      if (k == 2) begin bus.EN = 1'b1; bus.RS = 1'b1; bus.RW = 1'b0; bus.data = 8'h58; end
      if (k == 3) bus.EN = 1'b0;
      if (k == 4) begin
        chk("clr_overrun", {31'd0, overrun}, 32'd1);
        chk("clr_ac_after_overrun", {25'd0, ac}, 32'h0);
        chk("clr_no_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      end
      if (k == 5) chk("clr_cell3_before", {24'd0, rd_char}, 32'h44);
      if (k == 6) chk("clr_cell3_after", {24'd0, rd_char}, 32'h20);
    end
    chk("clr_busy_len", bc, C);
    read_all("clr");

    // Reset in the middle of a clear.
    apply(row(0, 8'hCF, E, 7'h4F, 5'b10101, 0, 0, 0), 100);
    apply(row(1, 8'h5A, E, 7'h50, 5'b10101, 1, 31, 8'h5A), 101);
    strobe(1'b0, 1'b0, 8'h01);
    repeat (4) @(negedge clk);
    chk("mid_clr_cell31", {24'd0, rd_char}, 32'h5A);
    chk("mid_clr_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_char", {24'd0, rd_char}, 32'h20);
    chk("arst_ac", {25'd0, ac}, 32'h0);
    chk("arst_flags", {27'd0, flags}, 32'h01);
    chk("arst_busy_valid_err", {29'd0, busy, cmd_valid, overrun | rw_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_cell31", {24'd0, rd_char}, 32'h20);

    // Strobe on the last busy cycle is rejected.
    strobe(1'b0, 1'b0, 8'h0F);
    for (int k = 1; k <= E + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.EN = 1'b1; bus.RS = 1'b0; bus.data = 8'h08; end
      if (k == E) bus.EN = 1'b0;
    end
    chk("last_busy_overrun", {31'd0, overrun}, 32'd1);
    chk("last_busy_no_valid", {31'd0, cmd_valid}, 32'd0);
    chk("last_busy_disp_kept", {31'd0, disp_on}, 32'd1);
    chk("last_busy_idle", {31'd0, busy}, 32'd0);

    // Strobe on the first idle cycle is accepted.
    strobe(1'b0, 1'b0, 8'h0F);
    for (int k = 1; k <= E + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.EN = 1'b1; bus.RS = 1'b0; bus.data = 8'h08; end
      if (k == E + 1) bus.EN = 1'b0;
    end
    chk("first_idle_valid", {31'd0, cmd_valid}, 32'd1);
    chk("first_idle_disp_off", {31'd0, disp_on}, 32'd0);
    chk("first_idle_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Read strobe is flagged and otherwise ignored.
    apply(row(1, 8'h51, E, 7'h01, 5'b00001, 1, 0, 8'h51), 102);
    chk("pre_rw_err", {31'd0, rw_err}, 32'd0);
    strobe(1'b0, 1'b1, 8'h01);
    rd_addr = 5'd0;
    @(negedge clk);
    chk("rw_err_set", {31'd0, rw_err}, 32'd1);
    chk("rw_no_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rw_no_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rw_cell0_kept", {24'd0, rd_char}, 32'h51);
    chk("rw_ac_kept", {25'd0, ac}, 32'h01);
    chk("rw_still_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_receiver.md
# lcd_receiver

HD44780-compatible responder for the 8-bit LCD bus driven by the team's LCD display driver. It decodes command and data strobes and maintains a 2x16 character image, an address counter and display/cursor flags. The on-FPGA character image can be mirrored to other logic and the driver's command sequences can be checked cycle-accurately without a physical panel.

## Interface
Parameters:
- EXEC_CYCLES, 2000: busy time for every accepted command except clear/home; must be ≥1.
- CLEAR_CYCLES, 82000: busy time for clear (0x01) and home (0x02/0x03); must be ≥32.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- EN  in  1  bus enable; a high-to-low transition is a strobe.
- RW  in  1  bus read/write; 1 means read.
- RS  in  1  bus register select; 0 means command, 1 means data.
- data  in  8  bus data.
- rd_addr  in  5  image read address, {line, col[3:0]}.
- rd_char  out  8  image cell at rd_addr, registered.
- ac  out  7  DDRAM address counter.
- busy  out  1  command execution in progress.
- disp_on, cursor_on, blink_on, two_line, inc_mode  out  1 each  mode flags.
- cmd_valid  out  1  one-cycle pulse per accepted strobe.
- overrun  out  1  sticky: a strobe arrived while busy.
- rw_err  out  1  sticky: a strobe arrived with RW=1.

## Operation
- EN is registered to en_q; RS, RW and data are registered every cycle EN=1.
- A strobe is the cycle where en_q=1 and EN=0. A strobe uses the RS, RW and data values registered on the last EN-high cycle.
- Strobe with busy=1: no effect except overrun<=1. Strobe with RW=1: no effect except rw_err<=1. If both apply, both flags set.
- Accepted strobe: cmd_valid pulses the next cycle.

RS=1 (data write):
- If ac is in 0x00-0x0F or 0x40-0x4F, cell {ac[6], ac[3:0]} <= data. Otherwise the write is dropped.
- ac then steps by inc_mode.

RS=0 (command). The highest set bit of data selects the command:
- 1aaaaaaa: ac <= a when a is in 0x00-0x27 or 0x40-0x67; otherwise ignored.
- 01xxxxxx: CGRAM address; no effect.
- 001xLxxx: two_line <= L.
- 0001SRxx: if S=0, ac steps right (R=1) or left (R=0). If S=1, no effect.
- 00001DCB: disp_on <= D, cursor_on <= C, blink_on <= B.
- 000001Ix: inc_mode <= I.
- 0000001x: ac <= 0.
- 00000001: all 32 cells <= 0x20; ac <= 0; inc_mode <= 1.
- 00000000: no-op, but still busy for EXEC_CYCLES.

ac stepping:
- Increment: 0x27 -> 0x40, 0x67 -> 0x00.
- Decrement: 0x00 -> 0x67, 0x40 -> 0x27.

State machine:
- IDLE -> CLEAR on an accepted clear.
- IDLE -> BUSY on any other accepted strobe.
- CLEAR: writes cell index i (0..31) on its i-th cycle, then enters BUSY for the remaining count.
- BUSY -> IDLE when the down-counter reaches 0.

## Timing
- Reset values: rd_char=0x20, all cells=0x20, ac=0, busy=0, disp_on=0, cursor_on=0, blink_on=0, two_line=0, inc_mode=1, cmd_valid=0, overrun=0, rw_err=0. State is IDLE.
- Strobe at cycle t: register effects (ac, flags, cell write) are visible at t+1, and cmd_valid=1 at t+1.
- busy=1 from t+1 through t+EXEC_CYCLES, or t+CLEAR_CYCLES for clear and home.
- Clear: cell i holds 0x20 at t+2+i; ac=0 at t+1.
- A strobe on the last busy cycle is rejected. A strobe on the first cycle with busy=0 is accepted.
- rd_char = cell[rd_addr], one cycle after rd_addr is presented. A same-cycle write returns the old value.
- Reset asserted mid-CLEAR or mid-BUSY returns every output to its reset value immediately.
- Back-to-back strobes need at least one EN-high cycle between them. EN held low generates no strobes.

## Test plan
- Reset, then read all 32 cells -> every rd_char=0x20; ac=0, inc_mode=1, busy=0.
- Strobe commands 0x38, 0x0E, 0x06 -> two_line=1, disp_on=1, cursor_on=1, blink_on=0, inc_mode=1. Each command gives busy high for EXEC_CYCLES and one cmd_valid pulse.
- Strobe 0x80, then data 0x4C,0x4F,0x41,0x44 -> cells 0..3 = "LOAD" and ac=0x04. Six 0x14 commands -> ac=0x0A. Then data 0x5B -> cell 10 = '[' and ac=0x0B.
- Strobe 0xA7 then data 0x41 -> write dropped, ac=0x40. Strobe 0xC0, data 0x2B -> cell 16 = '+' and ac=0x41. Strobe 0x04, then data 0x30 at ac=0x40 -> ac=0x27.
- Strobe 0x01 with cells populated -> busy held for exactly CLEAR_CYCLES and cells cleared in index order. A strobe mid-clear gives overrun=1 and leaves the image unchanged. Assert rst_n low mid-clear -> all outputs at reset values.
- Strobe with RW=1 and data=0x01 -> image untouched, rw_err=1, busy stays 0, no cmd_valid pulse.
